ifq_fetch_queue: RTL and testbench

- Fetch stage directly downstream of the program-counter register.
- Takes the current fetch address, issues requests to instruction memory, and tracks outstanding requests.
- Buffers returned instructions with their PC and hands {pc, instr} to decode over a valid/ready handshake.
- Supports pipeline flush on branch/jump redirect, including squashing responses already in flight.

---
 rtl/ifq_pkg.sv | 18 +
 rtl/ifq_fifo.sv | 42 ++++
 rtl/ifq_fetch_queue.sv | 142 ++++++++++++++
 tb/tb_ifq_fetch_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

    function automatic logic [XLEN-1:0] word_align(
        input logic [XLEN-1:0] addr
    );
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a clearing flush input.
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (i_flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (i_push) wptr <= wptr + (AW+1)'(1);
            if (i_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) mem[wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = mem[rptr[AW-1:0]];
    assign o_count = wptr - rptr;

endmodule

// File: rtl/ifq_fetch_queue.sv
// Fetch stage: issues imem requests, tracks in-flight fetches, queues to decode.
// Optional same-cycle response bypass to decode under IFQ_BYPASS_EN.
module ifq_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_pc_valid,
    output logic            o_pc_ready,
    input  logic            i_flush,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_instr_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    input  logic            i_instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int DW = OW + 2;

    logic [OW-1:0]   outstanding;
    logic [DW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic [CW-1:0]   p_count;
    ifq_entry_t      q_head;
    ifq_entry_t      byp_entry;
    ifq_entry_t      out_entry;
    logic [XLEN-1:0] p_head;

    logic credit;
    logic grant;
    logic rv_drop;
    logic rv_take;
    logic rv_hit;
    logic byp;
    logic q_nonempty;
    logic q_push;
    logic q_pop;

    assign credit = (32'(q_count) + 32'(outstanding) < 32'(DEPTH))
                 && (32'(outstanding) < 32'(MAX_OUTSTANDING));

    assign o_imem_req  = i_rst & i_pc_valid & credit & !i_flush;
    assign o_imem_addr = i_rst ? word_align(i_pc) : '0;
    assign grant       = o_imem_req & i_imem_gnt;
    assign o_pc_ready  = grant;

    // A stray rvalid with nothing in flight hits neither counter.
    assign rv_drop = i_imem_rvalid & (drop_cnt != '0);
    assign rv_take = i_imem_rvalid & (drop_cnt == '0)
                   & (outstanding != '0);
    assign rv_hit  = rv_drop | rv_take;

    assign q_nonempty = (q_count != '0);

`ifdef IFQ_BYPASS_EN
    assign byp = rv_take & !q_nonempty & i_instr_ready & !i_flush;
`else
    assign byp = 1'b0;
`endif

    assign q_push = rv_take & !byp;
    assign q_pop  = q_nonempty & i_instr_ready;

    assign byp_entry.pc    = p_head;
    assign byp_entry.instr = i_imem_rdata;

    ifq_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pend (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_push  (grant),
        .i_wdata (i_pc),
        .i_pop   (rv_take),
        .o_rdata (p_head),
        .o_count (p_count)
    );

    ifq_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_push  (q_push),
        .i_wdata (byp_entry),
        .i_pop   (q_pop),
        .o_rdata (q_head),
        .o_count (q_count)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (i_flush) begin
            outstanding <= '0;
            drop_cnt    <= drop_cnt + DW'(outstanding)
                         - DW'(rv_hit);
        end else begin
            outstanding <= outstanding + OW'(grant)
                         - OW'(rv_take);
            if (rv_drop) drop_cnt <= drop_cnt - DW'(1);
        end
    end

    always_comb begin
        out_entry = '0;
        if (q_nonempty) out_entry = q_head;
        else if (byp)   out_entry = byp_entry;
    end

    assign o_instr_valid = q_nonempty | byp;
    assign o_instr       = out_entry.instr;
    assign o_instr_pc    = out_entry.pc;

`ifndef SYNTHESIS
    a_no_stray_rvalid: assert property (
        @(posedge i_clk) disable iff (!i_rst)
        !(i_imem_rvalid && outstanding == '0 && drop_cnt == '0)
    ) else $error("ifq: rvalid with nothing in flight");

    a_pend_tracks: assert property (
        @(posedge i_clk) disable iff (!i_rst)
        32'(p_count) == 32'(outstanding)
    ) else $error("ifq: pending fifo out of step");
`endif

endmodule

// File: tb/tb_ifq_fetch_queue.sv
// Directed bench for ifq_fetch_queue.
module tb_ifq_fetch_queue;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_pc;
    logic        i_pc_valid;
    logic        o_pc_ready;
    logic        i_flush;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready;

    int checks = 0;
    int failures = 0;

    ifq_fetch_queue dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pc          (i_pc),
        .i_pc_valid    (i_pc_valid),
        .o_pc_ready    (o_pc_ready),
        .i_flush       (i_flush),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .i_instr_ready (i_instr_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic nxt();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_pc          = '0;
        i_pc_valid    = 1'b0;
        i_flush       = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
        i_instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        i_rst = 1'b0;
        i_pc = 32'h0000_1234;
        i_pc_valid = 1'b1;
        i_imem_gnt = 1'b1;
        nxt(); nxt();
        #1;
        checks++;
        if (o_imem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_req got=%b exp=0", o_imem_req);
        end
        checks++;
        if (o_imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=0", o_imem_addr);
        end
        checks++;
        if (o_pc_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_pc_ready got=%b exp=0", o_pc_ready);
        end
        checks++;
        if (o_instr_valid !== 1'b0 || o_instr !== 32'h0 || o_instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_decode got=%b/%h/%h exp=0/0/0",
                     o_instr_valid, o_instr, o_instr_pc);
        end
        idle();
        nxt();
        i_rst = 1'b1;
        nxt();
    endtask

    task automatic test_single();
        i_pc = 32'h0; i_pc_valid = 1'b1; i_imem_gnt = 1'b1;
        i_instr_ready = 1'b1;
        #1;
        checks++;
        if (o_imem_req !== 1'b1 || o_pc_ready !== 1'b1 || o_imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL single_req got=%b/%b/%h exp=1/1/0",
                     o_imem_req, o_pc_ready, o_imem_addr);
        end
        nxt();
        i_pc_valid = 1'b0; i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0050_0093;
        #1;
`ifdef IFQ_BYPASS_EN
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr !== 32'h0050_0093 || o_instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%b/%h/%h exp=1/00500093/0",
                     o_instr_valid, o_instr, o_instr_pc);
        end
        nxt();
        i_imem_rvalid = 1'b0;
        #1;
        checks++;
        if (o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL bypass_not_queued got=%b exp=0", o_instr_valid);
        end
`else
        checks++;
        if (o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency got=%b exp=0", o_instr_valid);
        end
        nxt();
        i_imem_rvalid = 1'b0;
        #1;
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr !== 32'h0050_0093 || o_instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL single_out got=%b/%h/%h exp=1/00500093/0",
                     o_instr_valid, o_instr, o_instr_pc);
        end
`endif
        nxt();
        checks++;
        if (o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got=%b exp=0", o_instr_valid);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        i_pc = 32'h0; i_pc_valid = 1'b1; i_imem_gnt = 1'b1;
        #1;
        checks++;
        if (o_pc_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_grant0 got=%b exp=1", o_pc_ready);
        end
        nxt();
        i_pc = 32'h4;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'hA000_0000;
        #1;
        checks++;
        if (o_pc_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_grant4 got=%b exp=1", o_pc_ready);
        end
        nxt();
        i_pc = 32'h8;
        i_imem_rdata = 32'hA000_0004;
        #1;
        checks++;
        if (o_pc_ready !== 1'b0 || o_imem_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall8 got=%b/%b exp=0/0", o_pc_ready, o_imem_req);
        end
        nxt();
        i_imem_rvalid = 1'b0;
        #1;
        checks++;
        if (o_pc_ready !== 1'b0 || o_instr_valid !== 1'b1 || o_instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL b2b_full got=%b/%b/%h exp=0/1/0",
                     o_pc_ready, o_instr_valid, o_instr_pc);
        end
        nxt();
        i_instr_ready = 1'b1;
        #1;
        checks++;
        if (o_pc_ready !== 1'b0 || o_instr !== 32'hA000_0000) begin
            failures++;
            $display("FAIL b2b_pop_no_credit got=%b/%h exp=0/a0000000",
                     o_pc_ready, o_instr);
        end
        nxt();
        #1;
        checks++;
        if (o_pc_ready !== 1'b1 || o_imem_addr !== 32'h8 || o_instr_pc !== 32'h4
            || o_instr !== 32'hA000_0004) begin
            failures++;
            $display("FAIL b2b_resume8 got=%b/%h/%h/%h exp=1/8/4/a0000004",
                     o_pc_ready, o_imem_addr, o_instr_pc, o_instr);
        end
        nxt();
        i_pc = 32'hC; i_instr_ready = 1'b0;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'hA000_0008;
        #1;
        checks++;
        if (o_pc_ready !== 1'b1 || o_imem_addr !== 32'hC || o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_resumeC got=%b/%h/%b exp=1/c/0",
                     o_pc_ready, o_imem_addr, o_instr_valid);
        end
        nxt();
        i_pc_valid = 1'b0; i_imem_gnt = 1'b0;
        i_imem_rdata = 32'hA000_000C; i_instr_ready = 1'b1;
        #1;
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h8 || o_instr !== 32'hA000_0008) begin
            failures++;
            $display("FAIL pushpop_head got=%b/%h/%h exp=1/8/a0000008",
                     o_instr_valid, o_instr_pc, o_instr);
        end
        nxt();
        i_imem_rvalid = 1'b0;
        #1;
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'hC || o_instr !== 32'hA000_000C) begin
            failures++;
            $display("FAIL pushpop_next got=%b/%h/%h exp=1/c/a000000c",
                     o_instr_valid, o_instr_pc, o_instr);
        end
        nxt();
        checks++;
        if (o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got=%b exp=0", o_instr_valid);
        end
        idle();
    endtask

    task automatic test_flush();
        idle();
        i_pc = 32'h10; i_pc_valid = 1'b1; i_imem_gnt = 1'b1;
        nxt();
        i_pc = 32'h14;
        nxt();
        i_pc = 32'h100; i_flush = 1'b1;
        #1;
        checks++;
        if (o_imem_req !== 1'b0 || o_pc_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_req got=%b/%b exp=0/0", o_imem_req, o_pc_ready);
        end
        nxt();
        i_flush = 1'b0;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_0010;
        #1;
        checks++;
        if (o_pc_ready !== 1'b1 || o_imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL flush_refetch got=%b/%h exp=1/100", o_pc_ready, o_imem_addr);
        end
        nxt();
        i_pc_valid = 1'b0; i_imem_gnt = 1'b0;
        i_imem_rdata = 32'hDEAD_0014;
        #1;
        checks++;
        if (o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop1 got=%b exp=0", o_instr_valid);
        end
        nxt();
        i_imem_rdata = 32'h1111_1111;
        #1;
        checks++;
        if (o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop2 got=%b exp=0", o_instr_valid);
        end
        nxt();
        i_imem_rvalid = 1'b0;
        #1;
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h100 || o_instr !== 32'h1111_1111) begin
            failures++;
            $display("FAIL flush_newpath got=%b/%h/%h exp=1/100/11111111",
                     o_instr_valid, o_instr_pc, o_instr);
        end
        i_instr_ready = 1'b1;
        nxt();
        idle();
    endtask

    task automatic test_flush_rvalid();
        idle();
        i_pc = 32'h20; i_pc_valid = 1'b1; i_imem_gnt = 1'b1;
        nxt();
        i_pc_valid = 1'b0; i_imem_gnt = 1'b0;
        i_flush = 1'b1; i_imem_rvalid = 1'b1; i_imem_rdata = 32'hBAD0_0020;
        nxt();
        i_flush = 1'b0; i_imem_rvalid = 1'b0;
        i_pc = 32'h200; i_pc_valid = 1'b1; i_imem_gnt = 1'b1;
        #1;
        checks++;
        if (o_pc_ready !== 1'b1 || o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL flushrv_req got=%b/%b exp=1/0", o_pc_ready, o_instr_valid);
        end
        nxt();
        i_pc_valid = 1'b0; i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h2222_2222;
        nxt();
        i_imem_rvalid = 1'b0;
        #1;
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h200 || o_instr !== 32'h2222_2222) begin
            failures++;
            $display("FAIL flushrv_accept got=%b/%h/%h exp=1/200/22222222",
                     o_instr_valid, o_instr_pc, o_instr);
        end
        i_instr_ready = 1'b1;
        nxt();
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        i_pc = 32'h40; i_pc_valid = 1'b1; i_imem_gnt = 1'b1;
        nxt();
        i_pc_valid = 1'b0; i_imem_gnt = 1'b0;
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h3333_3333;
        nxt();
        i_imem_rvalid = 1'b0;
        #1;
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr_pc !== 32'h40) begin
            failures++;
            $display("FAIL midrst_pre got=%b/%h exp=1/40", o_instr_valid, o_instr_pc);
        end
        i_rst = 1'b0;
        #1;
        checks++;
        if (o_instr_valid !== 1'b0 || o_instr !== 32'h0) begin
            failures++;
            $display("FAIL midrst_async got=%b/%h exp=0/0", o_instr_valid, o_instr);
        end
        nxt();
        i_rst = 1'b1;
        nxt();
        checks++;
        if (o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_post got=%b exp=0", o_instr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_flush();
        test_flush_rvalid();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
